// File: rtl/svi_kbd_pkg.sv
// Shared definitions for the SVI-328 keyboard matrix converter.
// Holds the matrix geometry constants, the decoded-key record and the
// PS/2 set-2 scancode to SVI matrix position lookup.
package svi_kbd_pkg;

   localparam int SVI_ROWS  = 11;
   localparam int SHIFT_ROW = 6;
   localparam int SHIFT_COL = 0;

   typedef struct packed {
      logic       valid;
      logic [3:0] row;
      logic [2:0] col;
      logic       is_shift;
   } svi_key_t;

   // Maps {ext, code} to a matrix cell. The case items assign the position
   // as a single number row*8+col, so 17 means row 2 col 1 ('A').
   // E0-prefixed codes appear as 9'h1xx.
   function automatic svi_key_t svi_keymap(input logic ext, input logic [7:0] code);
      svi_key_t   k;
      logic [6:0] rc;
      logic       hit;
      hit = 1'b1;
      rc  = '0;
      k   = '0;
      case ({ext, code})
         9'h045: rc = 7'd0;   9'h016: rc = 7'd1;   9'h01E: rc = 7'd2;   9'h026: rc = 7'd3;
         9'h025: rc = 7'd4;   9'h02E: rc = 7'd5;   9'h036: rc = 7'd6;   9'h03D: rc = 7'd7;
         9'h03E: rc = 7'd8;   9'h046: rc = 7'd9;   9'h04C: rc = 7'd10;  9'h052: rc = 7'd11;
         9'h041: rc = 7'd12;  9'h055: rc = 7'd13;  9'h049: rc = 7'd14;  9'h04A: rc = 7'd15;
         9'h04E: rc = 7'd16;  9'h01C: rc = 7'd17;  9'h032: rc = 7'd18;  9'h021: rc = 7'd19;
         9'h023: rc = 7'd20;  9'h024: rc = 7'd21;  9'h02B: rc = 7'd22;  9'h034: rc = 7'd23;
         9'h033: rc = 7'd24;  9'h043: rc = 7'd25;  9'h03B: rc = 7'd26;  9'h042: rc = 7'd27;
         9'h04B: rc = 7'd28;  9'h03A: rc = 7'd29;  9'h031: rc = 7'd30;  9'h044: rc = 7'd31;
         9'h04D: rc = 7'd32;  9'h015: rc = 7'd33;  9'h02D: rc = 7'd34;  9'h01B: rc = 7'd35;
         9'h02C: rc = 7'd36;  9'h03C: rc = 7'd37;  9'h02A: rc = 7'd38;  9'h01D: rc = 7'd39;
         9'h022: rc = 7'd40;  9'h035: rc = 7'd41;  9'h01A: rc = 7'd42;  9'h054: rc = 7'd43;
         9'h05D: rc = 7'd44;  9'h05B: rc = 7'd45;  9'h066: rc = 7'd46;  9'h175: rc = 7'd47;
         9'h012, 9'h059:      rc = 7'd48;
         9'h014, 9'h114:      rc = 7'd49;
         9'h011: rc = 7'd50;  9'h111: rc = 7'd51;  9'h076: rc = 7'd52;  9'h007: rc = 7'd53;
         9'h05A: rc = 7'd54;  9'h16B: rc = 7'd55;
         9'h005: rc = 7'd56;  9'h006: rc = 7'd57;  9'h004: rc = 7'd58;  9'h00C: rc = 7'd59;
         9'h003: rc = 7'd60;  9'h16C: rc = 7'd61;  9'h170: rc = 7'd62;  9'h172: rc = 7'd63;
         9'h029: rc = 7'd64;  9'h00D: rc = 7'd65;  9'h171: rc = 7'd66;  9'h058: rc = 7'd67;
         9'h00B: rc = 7'd68;  9'h083: rc = 7'd69;  9'h174: rc = 7'd71;
         9'h070: rc = 7'd72;  9'h069: rc = 7'd73;  9'h072: rc = 7'd74;  9'h07A: rc = 7'd75;
         9'h06B: rc = 7'd76;  9'h073: rc = 7'd77;  9'h074: rc = 7'd78;  9'h06C: rc = 7'd79;
         9'h075: rc = 7'd80;  9'h07D: rc = 7'd81;  9'h079: rc = 7'd82;  9'h07B: rc = 7'd83;
         9'h07C: rc = 7'd84;  9'h14A: rc = 7'd85;  9'h071: rc = 7'd86;  9'h15A: rc = 7'd87;
         default: hit = 1'b0;
      endcase
      k.valid    = hit;
      k.row      = rc[6:3];
      k.col      = rc[2:0];
      k.is_shift = hit && !ext && (code == 8'h12 || code == 8'h59);
      return k;
   endfunction

endpackage

// File: rtl/svi_key_matrix.sv
// PS/2 event to SVI-328 keyboard matrix converter.
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   keys      PS/2 event bus {toggle, make, ext, code[7:0]}
//   svi_row   row select from the console PPI
//   svi_col   registered column bits of the selected row
//   key_event one-cycle pulse when a mapped event updates the matrix
module svi_key_matrix
   import svi_kbd_pkg::*;
#(
   parameter int NUM_ROWS   = 11,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] keys,
   input  logic [3:0]  svi_row,
   output logic [7:0]  svi_col,
   output logic        key_event
);

   localparam int         ROW_LIMIT = (NUM_ROWS < SVI_ROWS) ? NUM_ROWS : SVI_ROWS;
   localparam logic [7:0] IDLE_COL  = ACTIVE_LOW ? 8'hFF : 8'h00;

   logic                         toggle_prev;
   logic                         s0_valid, s0_pressed, s0_ext;
   logic [7:0]                   s0_code;
   svi_key_t                     s0_key;
   logic                         s1_valid, s1_pressed, s1_shift, s1_right;
   logic [3:0]                   s1_row;
   logic [2:0]                   s1_col;
   logic [SVI_ROWS-1:0][7:0]     matrix;
   logic                         shift_l, shift_r;
   logic [7:0]                   row_bits;

   // Event detect: a change on the toggle bit marks a new PS/2 event.
   // Loading the history during reset keeps the exit from reset quiet.
   always_ff @(posedge clk) begin
      toggle_prev <= keys[10];
      if (reset) begin
         s0_valid   <= 1'b0;
         s0_pressed <= 1'b0;
         s0_ext     <= 1'b0;
         s0_code    <= '0;
      end else begin
         s0_valid   <= keys[10] ^ toggle_prev;
         s0_pressed <= keys[9];
         s0_ext     <= keys[8];
         s0_code    <= keys[7:0];
      end
   end

   assign s0_key = svi_keymap(s0_ext, s0_code);

   // Lookup stage: unmapped codes are dropped here, and key_event is
   // registered so it lines up with the cycle the matrix is written.
   // The two shift keys share one cell, so remember which one this is.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_pressed <= 1'b0;
         s1_shift   <= 1'b0;
         s1_right   <= 1'b0;
         s1_row     <= '0;
         s1_col     <= '0;
         key_event  <= 1'b0;
      end else begin
         s1_valid   <= s0_valid & s0_key.valid;
         s1_pressed <= s0_pressed;
         s1_shift   <= s0_key.is_shift;
         s1_right   <= (s0_code == 8'h59);
         s1_row     <= s0_key.row;
         s1_col     <= s0_key.col;
         key_event  <= s0_valid & s0_key.valid;
      end
   end

   // Matrix write: shift keys go to their own flags so that releasing
   // one while the other is held leaves SHIFT asserted.
   always_ff @(posedge clk) begin
      if (reset) begin
         matrix  <= '0;
         shift_l <= 1'b0;
         shift_r <= 1'b0;
      end else if (s1_valid) begin
         if (s1_shift) begin
            if (s1_right) shift_r <= s1_pressed;
            else          shift_l <= s1_pressed;
         end else if (s1_row < 4'(ROW_LIMIT)) begin
            matrix[s1_row][s1_col] <= s1_pressed;
         end
      end
   end

   // Read mux: pressed state is kept active-high internally, the shift
   // cell is the OR of both flags, and unimplemented rows read idle.
   always_comb begin
      row_bits = '0;
      if (svi_row < 4'(ROW_LIMIT)) begin
         row_bits = matrix[svi_row];
         if (svi_row == 4'(SHIFT_ROW)) row_bits[SHIFT_COL] = shift_l | shift_r;
      end
   end

   // Registered read port; a same-cycle write is seen one cycle later.
   always_ff @(posedge clk) begin
      if (reset) svi_col <= IDLE_COL;
      else       svi_col <= ACTIVE_LOW ? ~row_bits : row_bits;
   end

endmodule

// File: tb/tb_svi_key_matrix.sv
// Directed self-checking bench for svi_key_matrix (default parameters,
// active-low columns). Inputs change 1 ns after each rising edge and
// outputs are sampled at the same point.
module tb_svi_key_matrix;

   logic        clk;
   logic        reset;
   logic [10:0] keys;
   logic [3:0]  svi_row;
   logic [7:0]  svi_col;
   logic        key_event;

   int test_count;
   int fail_count;

   svi_key_matrix dut (
      .clk       (clk),
      .reset     (reset),
      .keys      (keys),
      .svi_row   (svi_row),
      .svi_col   (svi_col),
      .key_event (key_event)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One immediate-assertion comparison point.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      test_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present a new PS/2 event by flipping the toggle bit, then advance one cycle.
   task automatic applyStimulus(input logic make, input logic ext, input logic [7:0] code);
      keys = {~keys[10], make, ext, code};
      tick();
   endtask

   // Full event: after return the matrix holds the update (cycle N+3).
   task automatic sendKey(input string tag, input logic make, input logic ext,
                          input logic [7:0] code, input logic expect_event);
      applyStimulus(make, ext, code);
      tick();
      checkOutput(tag, {7'b0, key_event}, {7'b0, expect_event});
      tick();
   endtask

   task automatic readRow(input string tag, input logic [3:0] row, input logic [7:0] expected);
      svi_row = row;
      tick();
      checkOutput(tag, svi_col, expected);
   endtask

   initial begin
      test_count = 0;
      fail_count = 0;
      reset      = 1'b1;
      keys       = 11'h400;
      svi_row    = 4'd0;

      // Reset with toggle high, then release: nothing may fire.
      repeat (5) tick();
      checkOutput("reset_col", svi_col, 8'hFF);
      checkOutput("reset_event", {7'b0, key_event}, 8'h00);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("post_reset_event", {7'b0, key_event}, 8'h00);
      end
      for (int r = 0; r < 16; r++) readRow($sformatf("idle_row%0d", r), 4'(r), 8'hFF);

      // 'A' make with row 2 selected: event at +2, old value at +3, new at +4.
      svi_row = 4'd2;
      applyStimulus(1'b1, 1'b0, 8'h1C);
      checkOutput("a_event_early", {7'b0, key_event}, 8'h00);
      tick();
      checkOutput("a_event", {7'b0, key_event}, 8'h01);
      tick();
      checkOutput("a_event_clear", {7'b0, key_event}, 8'h00);
      checkOutput("a_prewrite", svi_col, 8'hFF);
      tick();
      checkOutput("a_pressed", svi_col, 8'hFD);
      sendKey("a_break_event", 1'b0, 1'b0, 8'h1C, 1'b1);
      readRow("a_released", 4'd2, 8'hFF);

      // Two shifts: releasing one keeps SHIFT asserted.
      sendKey("lshift_make", 1'b1, 1'b0, 8'h12, 1'b1);
      sendKey("rshift_make", 1'b1, 1'b0, 8'h59, 1'b1);
      sendKey("lshift_break", 1'b0, 1'b0, 8'h12, 1'b1);
      readRow("shift_held", 4'd6, 8'hFE);
      sendKey("rshift_break", 1'b0, 1'b0, 8'h59, 1'b1);
      readRow("shift_released", 4'd6, 8'hFF);

      // Extended flag selects UP versus keypad 8.
      sendKey("up_make", 1'b1, 1'b1, 8'h75, 1'b1);
      sendKey("kp8_make", 1'b1, 1'b0, 8'h75, 1'b1);
      readRow("up_row5", 4'd5, 8'h7F);
      readRow("kp8_row10", 4'd10, 8'hFE);
      sendKey("up_break", 1'b0, 1'b1, 8'h75, 1'b1);
      sendKey("kp8_break", 1'b0, 1'b0, 8'h75, 1'b1);
      readRow("up_clear", 4'd5, 8'hFF);
      readRow("kp8_clear", 4'd10, 8'hFF);

      // Unmapped code changes nothing and does not pulse.
      sendKey("unmapped_event", 1'b1, 1'b0, 8'h00, 1'b0);
      for (int r = 0; r < 11; r++) readRow($sformatf("unmapped_row%0d", r), 4'(r), 8'hFF);

      // Back-to-back toggles on consecutive cycles.
      applyStimulus(1'b1, 1'b0, 8'h16);
      applyStimulus(1'b1, 1'b0, 8'h29);
      checkOutput("b2b_event1", {7'b0, key_event}, 8'h01);
      tick();
      checkOutput("b2b_event2", {7'b0, key_event}, 8'h01);
      tick();
      readRow("b2b_row0", 4'd0, 8'hFD);
      readRow("b2b_row8", 4'd8, 8'hFE);

      // Typematic repeat keeps the cell; break of an idle key still pulses.
      sendKey("repeat_event", 1'b1, 1'b0, 8'h16, 1'b1);
      readRow("repeat_row0", 4'd0, 8'hFD);
      sendKey("idle_break_event", 1'b0, 1'b0, 8'h1C, 1'b1);
      readRow("idle_break_row2", 4'd2, 8'hFF);
      sendKey("one_break", 1'b0, 1'b0, 8'h16, 1'b1);
      sendKey("space_break", 1'b0, 1'b0, 8'h29, 1'b1);
      readRow("b2b_row0_clear", 4'd0, 8'hFF);
      readRow("b2b_row8_clear", 4'd8, 8'hFF);

      // 'A' held, then reset mid-stream with a '1' make in flight.
      sendKey("hold_a_event", 1'b1, 1'b0, 8'h1C, 1'b1);
      readRow("hold_a_row2", 4'd2, 8'hFD);
      readRow("hold_a_row13", 4'd13, 8'hFF);
      svi_row = 4'd2;
      applyStimulus(1'b1, 1'b0, 8'h16);
      reset = 1'b1;
      tick();
      checkOutput("midreset_col", svi_col, 8'hFF);
      checkOutput("midreset_event", {7'b0, key_event}, 8'h00);
      reset = 1'b0;
      tick();
      checkOutput("after_reset_row2", svi_col, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("inflight_dropped", {7'b0, key_event}, 8'h00);
      end
      readRow("inflight_row0", 4'd0, 8'hFF);
      readRow("after_reset_row13", 4'd13, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/svi_key_matrix.md
Name: svi_key_matrix

Overview:
- Converts PS/2 key events from the mist_io `ps2_key` bus into the SVI-328 11×8 keyboard matrix.
- Sits directly upstream of cv_console: the console drives `svi_row` (keyboard PPI port C) and reads `svi_col` back.
- Holds per-key pressed state, so multi-key combinations work, including SHIFT+letter and CTRL+STOP.

Parameters:
- NUM_ROWS, 11, number of implemented matrix rows; rows ≥ NUM_ROWS read idle.
- ACTIVE_LOW, 1, when 1 a pressed key reads 0 on `svi_col` (SVI PPI convention); when 0 a pressed key reads 1.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset  in  1  synchronous, active-high reset.
- keys  in  11  PS/2 event: [10] toggles once per new event, [9] 1 = make / 0 = break, [8] E0-extended flag, [7:0] set-2 scancode.
- svi_row  in  4  row select from the console.
- svi_col  out  8  column bits of the selected row.
- key_event  out  1  one-cycle pulse when a decoded, mapped event updates the matrix.

Behaviour:
- Reset (synchronous, active-high):
  - All matrix cells are released.
  - `svi_col` = 8'hFF if ACTIVE_LOW, else 8'h00.
  - `key_event` = 0.
  - The toggle-history register loads `keys[10]` so that leaving reset produces no spurious event.
  - Reset asserted mid-pipeline discards in-flight events.
- Event detect (cycle 0): event = `keys[10]` differs from the stored previous value. Capture {pressed, ext, code}; update the previous value every cycle.
- Stage 1 (cycle 1): lookup in the package function `svi_keymap(ext, code)`, which returns {valid, row[3:0], col[2:0], is_shift}. Unmapped codes return valid = 0.
- Stage 2 (cycle 2): write the matrix cell for valid events; `key_event` pulses in this same cycle. Invalid events change nothing and do not pulse.
- Latency: toggle at cycle N → matrix visible to `svi_col` reads from cycle N+3.
- Throughput: fully pipelined. A new toggle may be accepted every cycle with no drops.
- Shift handling: left shift (0x12) and right shift (0x59) are tracked in two separate flags. Matrix cell row 6 / col 0 = OR of both flags, so releasing one shift while the other is held keeps SHIFT asserted.
- Duplicate make of a held key (typematic repeat) leaves the cell pressed; `key_event` still pulses.
- Break of a key that is not pressed: cell stays released; `key_event` still pulses.
- Read path: `svi_col` is registered, so `svi_row` at cycle N gives the column data at N+1.
- Idle rows: `svi_row` ≥ NUM_ROWS (11..15) returns the idle value (FF for active-low).
- Simultaneous read and write of the same row in one cycle: the read returns the pre-write value; the update is visible the next cycle.
- Extended flag selects the map:
  - E0 75 = UP → row 5, col 7.
  - Plain 0x75 = keypad 8 → row 10, col 0.
- Matrix layout (row: cols 0..7):
  - 0: 0 1 2 3 4 5 6 7
  - 1: 8 9 : ' , = . /
  - 2: - A B C D E F G
  - 3: H I J K L M N O
  - 4: P Q R S T U V W
  - 5: X Y Z [ \ ] BS UP
  - 6: SHIFT CTRL LGRAPH RGRAPH ESC STOP ENTER LEFT
  - 7: F1 F2 F3 F4 F5 CLS INS DOWN
  - 8: SPACE TAB DEL CAPS SELECT PRINT – RIGHT
  - 9: KP0..KP7
  - 10: KP8 KP9 KP+ KP- KP* KP/ KP. KP,

Decomposition:
- Package `svi_kbd_pkg` contains:
  - constants SVI_ROWS = 11, SHIFT_ROW = 6, SHIFT_COL = 0;
  - the packed struct `svi_key_t` {valid, row, col, is_shift};
  - the function `svi_keymap` (a case on {ext, code}).
- No sub-module. The matrix is an 11×8 flop array; the two shift flags sit alongside it.

Test Plan:
- Reset held 5 cycles while `keys[10]` = 1, then released → no `key_event`; every row reads FF.
- Toggle with {make, ext 0, 0x1C} ('A') → `key_event` at +2; `svi_row` = 2 reads 8'hFD from cycle +3. Then a break of 0x1C → reads FF.
- Make 0x12, make 0x59, break 0x12 → row 6 reads 8'hFE; after break 0x59 → FF.
- Make E0 75, then make 0x75 → row 5 = 8'h7F and row 10 = 8'hFE simultaneously.
- Unmapped code 0x00 make → no `key_event`; all rows stay FF. Back-to-back toggles on consecutive cycles ('1' 0x16, space 0x29) → row 0 = FD and row 8 = FE, neither event lost.
- With 'A' held, assert reset mid-stream → row 2 reads FF the cycle after reset; `svi_row` = 13 reads FF at all times.
